tpu_top: RTL and testbench
==========================

# tpu_top

Single-clock Q5.3 fixed-point matrix-multiply accelerator with APB register control and two externally loadable 16-lane row memories (A and B). Software loads operands through the external memory ports, configures addresses, strides, masks and activation over APB, starts the engine, polls done, then reads result rows back from memory A. It is the top-level block of the small TPU subsystem.

## Interface
- DWIDTH, 8, element width (Q5.3 two's complement)
- AWIDTH, 10, memory row address width (1024 rows per memory)
- DESIGN_SIZE, 16, lanes per row and matrix dimension
- REG_DATAWIDTH, 32, APB data width; REG_ADDRWIDTH, 8, APB address width
- clk  in  1  sole clock
- resetn  in  1  asynchronous active-low reset
- PADDR  in  8  register byte address; PWRITE, PSEL, PENABLE  in  1 each  APB controls
- PWDATA  in  32  write data; PRDATA  out  32  read data; PREADY  out  1  always 1
- bram_addr_a_ext / bram_addr_b_ext  in  AWIDTH  external row address for A / B
- bram_wdata_a_ext / bram_wdata_b_ext  in  128  write row, lane k = bits [8k+7:8k]
- bram_we_a_ext / bram_we_b_ext  in  16  per-lane write enables
- bram_rdata_a_ext / bram_rdata_b_ext  out  128  registered read row

## Operation
- Registers (reset 0, R/W, unlisted addresses read 0, writes ignored): 0x00 ENABLES (bit0 matmul, bit3 activation); 0x04 START/DONE; 0x0E A base; 0x12 B base; 0x16 C base (low AWIDTH bits); 0x28/0x32/0x36 A/B/C strides (16 b); 0x20 A-row mask, 0x54 A-col mask, 0x5C B-row mask, 0x58 B-col mask (16 b); 0x3A ACT_CSR (bit0: 0 ReLU, 1 tanh); 0x24 ACCUM (stored, no function).
- 0x04 read: bit0 start, bit1 busy, bit31 done. Writing bit0=1 when idle and done=0 starts; writing bit0=0 clears done. Start while busy/done ignored.
- Memories: true dual-port, external port plus engine port; same-address same-cycle write: engine wins. No reset of contents.
- Compute, i,k,j in 0..15: C[i][j] = sum_k A[a_base+i*a_stride][lane k] * B[b_base+k*b_stride][lane j]; addresses mod 2^AWIDTH. Term k contributes 0 if A-col mask[k] or B-row mask[k] is 0.
- Arithmetic: 8x8 signed product (16 b, Q10.6), 24-bit signed accumulator; result = acc >>> 3 (arithmetic, floor), saturated to [-128,127].
- Activation (ENABLES bit3): ReLU maps negative to 0; tanh is hard-tanh clamp to [-8,+8] (±1.0).
- C row i written to memory A at c_base+i*c_stride, all 16 lanes; lane j forced 0 if B-col mask[j]=0. Rows with A-row mask[i]=0 are not written. Software keeps A and C regions disjoint.
- ENABLES bit0=0 at start: no memory access, done sets 2 cycles after start.
- FSM: IDLE -> READ (16 cycles, issue A row i and B row k) -> DRAIN (1 cycle) -> WRITE (1 cycle) -> next row or DONE; DONE holds until START cleared -> IDLE.

## Timing
- APB zero wait: write commits on edge with PSEL&PENABLE&PWRITE; PRDATA combinational, 0 unless PSEL&!PWRITE.
- Memory read latency 1 cycle on both ports; external reads valid the cycle after address presented.
- Per row 18 cycles; done set exactly 290 cycles after the edge capturing start (busy during 288 of them).
- Reset outputs: PRDATA 0, PREADY 1, rdata 0, FSM IDLE. resetn low mid-run aborts, clears registers, keeps memory contents.

## Configuration
- TPU_ACTIVATION_EN defined: activation stage and ACT_CSR implemented. Undefined: ENABLES bit3 ignored, ACT_CSR reads 0, result is saturated value only.

## Test plan
- Reset: all registers read 0, PREADY=1, rdata 0; write/readback 0x0E=0x1F3 returns 0x1F3.
- A row0 lanes 0x08, A rows1-15 0; B row0 lanes 0x04,0x08,...,0x80? no: 0x04..0x40 step 0x04, B rows1-15 0; masks 0xFFFF, bases 0/0x10/0x20, strides 1, ENABLES 1, start -> done after 290 cycles; A[0x20] = 0x04,0x08,...,0x40; A[0x21..0x2F] = 0.
- Saturation: A row0 0x08, all B rows 0x40 -> A[0x20] lanes 0x7F; B rows 0xC0 -> 0x80.
- A row0 lanes alternate 0x08/0xF8; B even rows lanes0-7 0x08, odd rows lanes8-15 0x08, else 0: ENABLES 1 -> lanes0-7 0x40, 8-15 0xC0; ENABLES 9 ReLU -> 0x40/0x00; tanh -> 0x08/0xF8.
- Masks: B-col 0x00FF, A-row 0x0001 -> row 0x20 lanes 8-15 = 0, row 0x21 unchanged from prior value.
- ENABLES 0, start -> done in 2 cycles, memory unchanged; start while busy ignored; START write 0 clears bit31.

Source files
------------

// File: rtl/tpu_top_if.sv
// APB register bus between the software host and tpu_top.
// The host drives the master side; tpu_top answers with zero wait states.
interface tpu_top_if #(
   parameter int REG_ADDRWIDTH = 8,
   parameter int REG_DATAWIDTH = 32
);
   logic [REG_ADDRWIDTH-1:0] PADDR;
   logic                     PWRITE;
   logic                     PSEL;
   logic                     PENABLE;
   logic [REG_DATAWIDTH-1:0] PWDATA;
   logic [REG_DATAWIDTH-1:0] PRDATA;
   logic                     PREADY;

   modport master (output PADDR, PWRITE, PSEL, PENABLE, PWDATA, input PRDATA, PREADY);
   modport slave  (input PADDR, PWRITE, PSEL, PENABLE, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/tpu_top.sv
// tpu_top: Q5.3 16x16 matrix-multiply engine with APB control and two dual-port row memories.
// Define TPU_ACTIVATION_EN to build the ReLU / hard-tanh activation stage and ACT_CSR.

module tpu_ram #(
   parameter int AWIDTH = 10,
   parameter int LANES  = 16,
   parameter int DWIDTH = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [AWIDTH-1:0]       ext_addr,
   input  logic [LANES*DWIDTH-1:0] ext_wdata,
   input  logic [LANES-1:0]        ext_we,
   output logic [LANES*DWIDTH-1:0] ext_rdata,
   input  logic [AWIDTH-1:0]       eng_addr,
   input  logic                    eng_re,
   input  logic [LANES*DWIDTH-1:0] eng_wdata,
   input  logic [LANES-1:0]        eng_we,
   output logic [LANES*DWIDTH-1:0] eng_rdata
);
   logic [DWIDTH-1:0] mem [2**AWIDTH][LANES];

   // Engine write is issued last so it overrides an external write to the same lane.
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (ext_we[l]) mem[ext_addr][l] <= ext_wdata[l*DWIDTH +: DWIDTH];
         if (eng_we[l]) mem[eng_addr][l] <= eng_wdata[l*DWIDTH +: DWIDTH];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ext_rdata <= '0;
         eng_rdata <= '0;
      end else begin
         for (int l = 0; l < LANES; l++) begin
            ext_rdata[l*DWIDTH +: DWIDTH] <= mem[ext_addr][l];
            if (eng_re) eng_rdata[l*DWIDTH +: DWIDTH] <= mem[eng_addr][l];
         end
      end
   end
endmodule

// state   | meaning
// IDLE    | waiting for START
// READ    | 16 cycles: issue A row i and B row k, accumulate lane k of the previous read
// DRAIN   | last B row returns and is accumulated
// WRITE   | C row i written to memory A, advance to next row
// DONE    | done flag set, held until START is written 0
module tpu_top #(
   parameter int DWIDTH        = 8,
   parameter int AWIDTH        = 10,
   parameter int DESIGN_SIZE   = 16,
   parameter int REG_DATAWIDTH = 32,
   parameter int REG_ADDRWIDTH = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   tpu_top_if.slave                      apb,
   input  logic [AWIDTH-1:0]             bram_addr_a_ext,
   input  logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata_a_ext,
   input  logic [DESIGN_SIZE-1:0]        bram_we_a_ext,
   output logic [DESIGN_SIZE*DWIDTH-1:0] bram_rdata_a_ext,
   input  logic [AWIDTH-1:0]             bram_addr_b_ext,
   input  logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata_b_ext,
   input  logic [DESIGN_SIZE-1:0]        bram_we_b_ext,
   output logic [DESIGN_SIZE*DWIDTH-1:0] bram_rdata_b_ext
);
   localparam int LW   = DESIGN_SIZE*DWIDTH;
   localparam int KW   = $clog2(DESIGN_SIZE);
   localparam int PW   = 2*DWIDTH;
   localparam int ACCW = 24;
   localparam int FRAC = 3;
   localparam logic signed [ACCW-1:0]   SAT_MAX = ACCW'((1 << (DWIDTH-1)) - 1);
   localparam logic signed [ACCW-1:0]   SAT_MIN = -SAT_MAX - ACCW'(1);
   localparam logic [KW-1:0]            K_LAST  = KW'(DESIGN_SIZE-1);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;
   state_t state, state_next;

   logic [3:0]             enables;
   logic                   start_reg, done_reg;
   logic [AWIDTH-1:0]      a_base, b_base, c_base;
   logic [15:0]            a_stride, b_stride, c_stride;
   logic [DESIGN_SIZE-1:0] a_row_mask, a_col_mask, b_row_mask, b_col_mask;
   logic [31:0]            accum_reg;
`ifdef TPU_ACTIVATION_EN
   logic                   act_csr;
`endif

   logic                   apb_wr, start_go, busy;
   logic [REG_DATAWIDTH-1:0] prdata;

   logic [KW-1:0]          k, row, acc_k;
   logic                   acc_en, term_on;
   logic [AWIDTH-1:0]      a_ptr, b_ptr, c_ptr;
   logic signed [ACCW-1:0] acc [DESIGN_SIZE];
   logic signed [PW-1:0]   prod [DESIGN_SIZE];
   logic signed [DWIDTH-1:0] a_elem;
   logic signed [ACCW-1:0] shifted;
   logic signed [DWIDTH-1:0] sat_v, act_v;
   logic [LW-1:0]          wdata_c, eng_rdata_a, eng_rdata_b;
   logic [AWIDTH-1:0]      eng_addr_a;
   logic [DESIGN_SIZE-1:0] eng_we_a;

   assign apb_wr   = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign start_go = apb_wr && (apb.PADDR == 8'h04) && apb.PWDATA[0]
                     && (state == S_IDLE) && !done_reg;
   assign busy     = (state == S_READ) || (state == S_DRAIN) || (state == S_WRITE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         enables    <= '0;
         start_reg  <= 1'b0;
         done_reg   <= 1'b0;
         a_base     <= '0;
         b_base     <= '0;
         c_base     <= '0;
         a_stride   <= '0;
         b_stride   <= '0;
         c_stride   <= '0;
         a_row_mask <= '0;
         a_col_mask <= '0;
         b_row_mask <= '0;
         b_col_mask <= '0;
         accum_reg  <= '0;
`ifdef TPU_ACTIVATION_EN
         act_csr    <= 1'b0;
`endif
      end else begin
         if (state == S_DONE && start_reg) done_reg <= 1'b1;
         if (start_go) start_reg <= 1'b1;
         if (apb_wr) begin
            case (apb.PADDR)
               8'h00: enables <= apb.PWDATA[3:0];
               8'h04: if (!apb.PWDATA[0]) begin
                         start_reg <= 1'b0;
                         done_reg  <= 1'b0;
                      end
               8'h0E: a_base     <= apb.PWDATA[AWIDTH-1:0];
               8'h12: b_base     <= apb.PWDATA[AWIDTH-1:0];
               8'h16: c_base     <= apb.PWDATA[AWIDTH-1:0];
               8'h28: a_stride   <= apb.PWDATA[15:0];
               8'h32: b_stride   <= apb.PWDATA[15:0];
               8'h36: c_stride   <= apb.PWDATA[15:0];
               8'h20: a_row_mask <= apb.PWDATA[DESIGN_SIZE-1:0];
               8'h54: a_col_mask <= apb.PWDATA[DESIGN_SIZE-1:0];
               8'h5C: b_row_mask <= apb.PWDATA[DESIGN_SIZE-1:0];
               8'h58: b_col_mask <= apb.PWDATA[DESIGN_SIZE-1:0];
               8'h24: accum_reg  <= apb.PWDATA;
`ifdef TPU_ACTIVATION_EN
               8'h3A: act_csr    <= apb.PWDATA[0];
`endif
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      prdata = '0;
      if (apb.PSEL && !apb.PWRITE) begin
         case (apb.PADDR)
            8'h00: prdata[3:0] = enables;
            8'h04: begin
               prdata[0]  = start_reg;
               prdata[1]  = busy;
               prdata[31] = done_reg;
            end
            8'h0E: prdata[AWIDTH-1:0]      = a_base;
            8'h12: prdata[AWIDTH-1:0]      = b_base;
            8'h16: prdata[AWIDTH-1:0]      = c_base;
            8'h28: prdata[15:0]            = a_stride;
            8'h32: prdata[15:0]            = b_stride;
            8'h36: prdata[15:0]            = c_stride;
            8'h20: prdata[DESIGN_SIZE-1:0] = a_row_mask;
            8'h54: prdata[DESIGN_SIZE-1:0] = a_col_mask;
            8'h5C: prdata[DESIGN_SIZE-1:0] = b_row_mask;
            8'h58: prdata[DESIGN_SIZE-1:0] = b_col_mask;
            8'h24: prdata                  = accum_reg;
`ifdef TPU_ACTIVATION_EN
            8'h3A: prdata[0]               = act_csr;
`endif
            default: ;
         endcase
      end
   end

   assign apb.PRDATA = prdata;
   assign apb.PREADY = 1'b1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start_reg) state_next = enables[0] ? S_READ : S_DONE;
         S_READ:  if (k == K_LAST) state_next = S_DRAIN;
         S_DRAIN: state_next = S_WRITE;
         S_WRITE: state_next = (row == K_LAST) ? S_DONE : S_READ;
         S_DONE:  if (!start_reg) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Read data lags the issued address by one cycle, so lane index k is delayed into acc_k.
   always_comb begin
      a_elem  = eng_rdata_a[acc_k*DWIDTH +: DWIDTH];
      term_on = a_col_mask[acc_k] & b_row_mask[acc_k];
      for (int j = 0; j < DESIGN_SIZE; j++)
         prod[j] = a_elem * $signed(eng_rdata_b[j*DWIDTH +: DWIDTH]);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         k      <= '0;
         row    <= '0;
         acc_k  <= '0;
         acc_en <= 1'b0;
         a_ptr  <= '0;
         b_ptr  <= '0;
         c_ptr  <= '0;
         for (int j = 0; j < DESIGN_SIZE; j++) acc[j] <= '0;
      end else begin
         acc_en <= (state == S_READ);
         acc_k  <= k;
         case (state)
            S_IDLE: begin
               k     <= '0;
               row   <= '0;
               a_ptr <= a_base;
               b_ptr <= b_base;
               c_ptr <= c_base;
            end
            S_READ: begin
               k     <= k + KW'(1);
               b_ptr <= b_ptr + b_stride[AWIDTH-1:0];
            end
            S_WRITE: begin
               k     <= '0;
               row   <= row + KW'(1);
               a_ptr <= a_ptr + a_stride[AWIDTH-1:0];
               b_ptr <= b_base;
               c_ptr <= c_ptr + c_stride[AWIDTH-1:0];
            end
            default: ;
         endcase
         if (state == S_READ && k == '0) begin
            for (int j = 0; j < DESIGN_SIZE; j++) acc[j] <= '0;
         end else if (acc_en && term_on) begin
            for (int j = 0; j < DESIGN_SIZE; j++)
               acc[j] <= acc[j] + {{(ACCW-PW){prod[j][PW-1]}}, prod[j]};
         end
      end
   end

   // Rescale Q10.6 sums to Q5.3 with floor, saturate, optionally activate, then apply column mask.
   always_comb begin
      wdata_c = '0;
      shifted = '0;
      sat_v   = '0;
      act_v   = '0;
      for (int j = 0; j < DESIGN_SIZE; j++) begin
         shifted = acc[j] >>> FRAC;
         if (shifted > SAT_MAX)      sat_v = SAT_MAX[DWIDTH-1:0];
         else if (shifted < SAT_MIN) sat_v = SAT_MIN[DWIDTH-1:0];
         else                        sat_v = shifted[DWIDTH-1:0];
         act_v = sat_v;
`ifdef TPU_ACTIVATION_EN
         if (enables[3]) begin
            if (!act_csr) begin
               if (sat_v < 0) act_v = '0;
            end else begin
               if (sat_v > $signed(DWIDTH'(1 << FRAC)))        act_v = DWIDTH'(1 << FRAC);
               else if (sat_v < -$signed(DWIDTH'(1 << FRAC)))  act_v = -$signed(DWIDTH'(1 << FRAC));
            end
         end
`endif
         wdata_c[j*DWIDTH +: DWIDTH] = b_col_mask[j] ? act_v : '0;
      end
   end

   assign eng_addr_a = (state == S_WRITE) ? c_ptr : a_ptr;
   assign eng_we_a   = {DESIGN_SIZE{(state == S_WRITE) && a_row_mask[row]}};

   tpu_ram #(.AWIDTH(AWIDTH), .LANES(DESIGN_SIZE), .DWIDTH(DWIDTH)) u_ram_a (
      .clk       (clk),
      .resetn    (resetn),
      .ext_addr  (bram_addr_a_ext),
      .ext_wdata (bram_wdata_a_ext),
      .ext_we    (bram_we_a_ext),
      .ext_rdata (bram_rdata_a_ext),
      .eng_addr  (eng_addr_a),
      .eng_re    (state == S_READ),
      .eng_wdata (wdata_c),
      .eng_we    (eng_we_a),
      .eng_rdata (eng_rdata_a)
   );

   tpu_ram #(.AWIDTH(AWIDTH), .LANES(DESIGN_SIZE), .DWIDTH(DWIDTH)) u_ram_b (
      .clk       (clk),
      .resetn    (resetn),
      .ext_addr  (bram_addr_b_ext),
      .ext_wdata (bram_wdata_b_ext),
      .ext_we    (bram_we_b_ext),
      .ext_rdata (bram_rdata_b_ext),
      .eng_addr  (b_ptr),
      .eng_re    (state == S_READ),
      .eng_wdata ('0),
      .eng_we    ('0),
      .eng_rdata (eng_rdata_b)
   );
endmodule

// File: tb/tb_tpu_top.sv
// Directed bench for tpu_top: register access, matmul results, saturation, activation, masks, timing.
module tb_tpu_top;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   tpu_top_if apb();
   logic [9:0]   addr_a, addr_b;
   logic [127:0] wdata_a, wdata_b, rdata_a, rdata_b;
   logic [15:0]  we_a, we_b;

   tpu_top dut (
      .clk              (clk),
      .resetn           (resetn),
      .apb              (apb),
      .bram_addr_a_ext  (addr_a),
      .bram_wdata_a_ext (wdata_a),
      .bram_we_a_ext    (we_a),
      .bram_rdata_a_ext (rdata_a),
      .bram_addr_b_ext  (addr_b),
      .bram_wdata_b_ext (wdata_b),
      .bram_we_b_ext    (we_b),
      .bram_rdata_b_ext (rdata_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = a; apb.PWDATA = d;
      @(negedge clk);
      apb.PENABLE = 1'b1;
      @(negedge clk);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
   endtask

   task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = a;
      #1 d = apb.PRDATA;
      apb.PSEL = 1'b0;
   endtask

   task automatic mem_wr(input bit sel_b, input logic [9:0] a, input logic [127:0] row);
      @(negedge clk);
      if (sel_b) begin addr_b = a; wdata_b = row; we_b = '1; end
      else       begin addr_a = a; wdata_a = row; we_a = '1; end
      @(negedge clk);
      we_a = '0; we_b = '0;
   endtask

   task automatic mem_rd_a(input logic [9:0] a, output logic [127:0] row);
      @(negedge clk);
      addr_a = a;
      @(negedge clk);
      row = rdata_a;
   endtask

   // Start, optionally re-issue START while busy, poll done and check timing, then clear.
   task automatic run(input string tag, input bit restart, input int exp_cyc, input int exp_busy);
      int cyc, bsy;
      logic [31:0] d;
      apb_wr(8'h04, 32'h1);
      cyc = 0; bsy = 0;
      if (restart) begin
         repeat (5) begin @(negedge clk); cyc++; end
         apb_wr(8'h04, 32'h1);
         cyc += 3; bsy = 7;
      end
      apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = 8'h04;
      #1;
      while (!apb.PRDATA[31] && cyc < 400) begin
         if (apb.PRDATA[1]) bsy++;
         @(negedge clk); cyc++; #1;
      end
      apb.PSEL = 1'b0;
      check({tag, "_cycles"}, cyc, exp_cyc);
      check({tag, "_busy"}, bsy, exp_busy);
      apb_wr(8'h04, 32'h1);
      apb_rd(8'h04, d);
      check({tag, "_status"}, d, 32'h8000_0001);
      apb_wr(8'h04, 32'h0);
      apb_rd(8'h04, d);
      check({tag, "_clear"}, d, 32'h0);
   endtask

   logic [7:0]   reg_list [14] = '{8'h00, 8'h04, 8'h0E, 8'h12, 8'h16, 8'h28, 8'h32,
                                   8'h36, 8'h20, 8'h54, 8'h5C, 8'h58, 8'h3A, 8'h24};
   logic [31:0]  rd;
   logic [127:0] row, exp_row, a_alt, b_even, b_odd, relu_row, tanh_row;

   initial begin
      apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;
      addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0; we_a = '0; we_b = '0;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdata_a", rdata_a, '0);
      check("rst_rdata_b", rdata_b, '0);
      check("rst_pready", apb.PREADY, 1'b1);
      check("rst_prdata_idle", apb.PRDATA, '0);
      resetn = 1'b1;

      foreach (reg_list[i]) begin
         apb_rd(reg_list[i], rd);
         check($sformatf("rst_reg_%h", reg_list[i]), rd, 32'h0);
      end
      apb_wr(8'h0E, 32'h1F3);
      apb_rd(8'h0E, rd);
      check("a_base_rw", rd, 32'h1F3);
      apb_wr(8'h24, 32'hDEAD_BEEF);
      apb_rd(8'h24, rd);
      check("accum_rw", rd, 32'hDEAD_BEEF);
      apb_wr(8'h08, 32'h1234);
      apb_rd(8'h08, rd);
      check("unmapped", rd, 32'h0);

      // Operands: A row0 = 1.0 everywhere, B row0 lane j = 0.5*(j+1)
      mem_wr(0, 10'h000, {16{8'h08}});
      for (int r = 1; r < 16; r++) mem_wr(0, 10'(r), '0);
      for (int r = 0; r < 16; r++) mem_wr(0, 10'(32 + r), {16{8'h55}});
      for (int j = 0; j < 16; j++) exp_row[8*j +: 8] = 8'(4*(j+1));
      mem_wr(1, 10'h010, exp_row);
      for (int r = 1; r < 16; r++) mem_wr(1, 10'(16 + r), '0);

      apb_wr(8'h0E, 32'h0);
      apb_wr(8'h12, 32'h10);
      apb_wr(8'h16, 32'h20);
      apb_wr(8'h28, 32'h1);
      apb_wr(8'h32, 32'h1);
      apb_wr(8'h36, 32'h1);
      apb_wr(8'h20, 32'hFFFF);
      apb_wr(8'h54, 32'hFFFF);
      apb_wr(8'h5C, 32'hFFFF);
      apb_wr(8'h58, 32'hFFFF);
      apb_wr(8'h00, 32'h1);
      apb_rd(8'h58, rd);
      check("bcol_rw", rd, 32'hFFFF);

      run("basic", 0, 290, 288);
      mem_rd_a(10'h020, row);
      check("basic_row20", row, exp_row);
      for (int r = 1; r < 16; r++) begin
         mem_rd_a(10'(32 + r), row);
         check($sformatf("basic_row%0h", 32 + r), row, '0);
      end

      for (int r = 0; r < 16; r++) mem_wr(1, 10'(16 + r), {16{8'h40}});
      run("sat_pos", 1, 290, 288);
      mem_rd_a(10'h020, row);
      check("sat_pos_row", row, {16{8'h7F}});
      for (int r = 0; r < 16; r++) mem_wr(1, 10'(16 + r), {16{8'hC0}});
      run("sat_neg", 0, 290, 288);
      mem_rd_a(10'h020, row);
      check("sat_neg_row", row, {16{8'h80}});

      // Alternating signs: even k feed lanes 0-7 with +1.0, odd k feed lanes 8-15 with -1.0
      a_alt  = {8{8'hF8, 8'h08}};
      b_even = {64'h0, {8{8'h08}}};
      b_odd  = {{8{8'h08}}, 64'h0};
      mem_wr(0, 10'h000, a_alt);
      for (int r = 0; r < 16; r++) mem_wr(1, 10'(16 + r), (r % 2 == 0) ? b_even : b_odd);
      run("alt", 0, 290, 288);
      mem_rd_a(10'h020, row);
      check("alt_row", row, {{8{8'hC0}}, {8{8'h40}}});

`ifdef TPU_ACTIVATION_EN
      relu_row = {{8{8'h00}}, {8{8'h40}}};
      tanh_row = {{8{8'hF8}}, {8{8'h08}}};
`else
      relu_row = {{8{8'hC0}}, {8{8'h40}}};
      tanh_row = {{8{8'hC0}}, {8{8'h40}}};
`endif
      apb_wr(8'h00, 32'h9);
      apb_wr(8'h3A, 32'h0);
      run("relu", 0, 290, 288);
      mem_rd_a(10'h020, row);
      check("relu_row", row, relu_row);
      apb_wr(8'h3A, 32'h1);
      apb_rd(8'h3A, rd);
`ifdef TPU_ACTIVATION_EN
      check("act_csr_rw", rd, 32'h1);
`else
      check("act_csr_rw", rd, 32'h0);
`endif
      run("tanh", 0, 290, 288);
      mem_rd_a(10'h020, row);
      check("tanh_row", row, tanh_row);
      apb_wr(8'h3A, 32'h0);
      apb_wr(8'h00, 32'h1);

      apb_wr(8'h54, 32'h5555);
      run("acol", 0, 290, 288);
      mem_rd_a(10'h020, row);
      check("acol_row", row, {64'h0, {8{8'h40}}});
      apb_wr(8'h54, 32'hFFFF);
      apb_wr(8'h5C, 32'hAAAA);
      run("brow", 0, 290, 288);
      mem_rd_a(10'h020, row);
      check("brow_row", row, {{8{8'hC0}}, 64'h0});
      apb_wr(8'h5C, 32'hFFFF);

      mem_wr(0, 10'h020, {16{8'h55}});
      mem_wr(0, 10'h021, {16{8'h5A}});
      apb_wr(8'h58, 32'h00FF);
      apb_wr(8'h20, 32'h0001);
      run("mask", 0, 290, 288);
      mem_rd_a(10'h020, row);
      check("mask_row20", row, {64'h0, {8{8'h40}}});
      mem_rd_a(10'h021, row);
      check("mask_row21", row, {16{8'h5A}});
      apb_wr(8'h58, 32'hFFFF);
      apb_wr(8'h20, 32'hFFFF);

      mem_wr(0, 10'h022, {16{8'h33}});
      apb_wr(8'h00, 32'h0);
      run("nomm", 0, 2, 0);
      mem_rd_a(10'h020, row);
      check("nomm_row20", row, {64'h0, {8{8'h40}}});
      mem_rd_a(10'h022, row);
      check("nomm_row22", row, {16{8'h33}});

      // Reset in the middle of a run: registers clear, memory survives
      apb_wr(8'h00, 32'h1);
      apb_wr(8'h04, 32'h1);
      repeat (20) @(negedge clk);
      resetn = 1'b0;
      apb_rd(8'h04, rd);
      check("midrst_status", rd, 32'h0);
      apb_rd(8'h00, rd);
      check("midrst_enables", rd, 32'h0);
      apb_rd(8'h12, rd);
      check("midrst_b_base", rd, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      mem_rd_a(10'h000, row);
      check("midrst_mem_a0", row, a_alt);
      mem_rd_a(10'h021, row);
      check("midrst_mem_a21", row, {16{8'h5A}});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
